bomb_engine: RTL and testbench
==============================

Name: bomb_engine

Overview:
- Parametrised successor to the fixed 10x10, 2-player bomb-map updater.
- Owns the bomb grid internally: accepts per-player placement requests, advances fuses, detonates bombs with a configurable cross-shaped blast and one-step-delayed chain reactions, applies damage to N players, and tracks game over.
- Sits between player-control logic and the VGA renderer. Advances one game step per bombClk edge.

Parameters:
- GRID_W, 10, grid columns (x = 0..GRID_W-1).
- GRID_H, 10, grid rows (y = 0..GRID_H-1).
- CW, 4, coordinate width; must satisfy 2^CW >= max(GRID_W, GRID_H).
- FUSE_LEN, 3, fuse states before detonation (>=1).
- FW, 2, fuse field width; must satisfy 2^FW > FUSE_LEN.
- BLAST_R, 2, blast radius in cells along each axis.
- NUM_PLAYERS, 2, number of players (2..4).
- HW, 2, health width.
- MAX_HEALTH, 3, health value loaded at reset.
- MAX_BOMBS, 1, maximum simultaneously active bombs per player.

Ports:
- bombClk, input, 1, game-step clock.
- rst, input, 1, synchronous active-high reset.
- i_place, input, NUM_PLAYERS, bomb placement request per player, sampled each edge.
- i_posX, input, NUM_PLAYERS*CW, player x positions, player p at [p*CW +: CW].
- i_posY, input, NUM_PLAYERS*CW, player y positions, same packing.
- o_bombMap, output, GRID_W*GRID_H*FW, fuse state per cell; cell (x,y) at index (y*GRID_W+x)*FW.
- o_blastMap, output, GRID_W*GRID_H, 1 = cell covered by a blast on the last edge.
- o_health, output, NUM_PLAYERS*HW, player health.
- o_alive, output, NUM_PLAYERS, 1 = health nonzero.
- o_game_over, output, 1, set when at most one player is alive.
- o_winner, output, 2, index of the sole surviving player (valid only with o_game_over and !o_draw).
- o_draw, output, 1, game over with zero players alive.

Behaviour:
- Interface: one clock, bombClk. Reset is synchronous and active-high on rst.
- Reset: all fuses 0, blast map 0, health MAX_HEALTH, alive all 1, per-player bomb counts 0, o_game_over/o_winner/o_draw all 0. rst overrides every other input on the same edge. Reset mid-game discards all bombs and pending chains immediately.
- All outputs are registered. Every update below takes effect on a single bombClk edge and is visible one edge after the stimulus is sampled.
- Cell fuse encoding: 0 = empty; 1..FUSE_LEN = ticking. Each cell also stores an owner index.
- Per edge, when not game over, evaluate in this order using current (pre-edge) state:
  1. Explosions: every cell with fuse == FUSE_LEN detonates. Its fuse goes to 0 and its owner's active count is decremented.
  2. Blast set: union, over all detonating cells, of the cross along the row and column within BLAST_R cells, clipped at the grid edges (no wrap). The result is registered into o_blastMap; cells outside the union are cleared.
  3. Chain reaction: any non-detonating bomb (1 <= fuse < FUSE_LEN) inside the blast set has its fuse set to FUSE_LEN, so it detonates on the next edge.
  4. Advance: all other bombs with 1 <= fuse < FUSE_LEN increment by 1.
  5. Damage: each alive player whose (x,y) lies in the blast set loses exactly 1 health, regardless of how many crosses cover it. Health saturates at 0. alive[p] is updated on the same edge.
  6. Placement: request p is accepted only if all of the following hold:
     - player p is alive (pre-edge);
     - the position is in range;
     - the cell has fuse 0 pre-edge;
     - the cell is not in this edge's blast set;
     - the player's active count is below MAX_BOMBS.
     An accepted request sets fuse 1, owner p, and increments the count. If a player's bomb explodes and that player places on the same edge, the net count change is 0.
  7. Same-cell conflict: if several players request the same cell, only the lowest-index eligible player is accepted.
- Out-of-range positions (x >= GRID_W or y >= GRID_H) never take damage and never place.
- Game over: evaluated from post-edge alive values, registered.
  - If the alive count <= 1, set o_game_over.
  - If the count is 1, o_winner = the surviving index and o_draw = 0.
  - If the count is 0, o_draw = 1 and o_winner = 0.
  - Once set, the entire state freezes, with o_blastMap cleared on the next edge, until rst.

Test Plan:
- Defaults. After rst, P0 at (3,3) places once. Required: o_bombMap(3,3) = 1, 2, 3 on the next three edges, then 0 with o_blastMap set on x=1..5 of y=3 and y=1..5 of x=3. P0 health 3 -> 2.
- Edge clip. Bomb at (0,0) detonates. Required: blast covers x=0..2 of y=0 and y=0..2 of x=0 only; no wrap to x=GRID_W-1.
- Chain reaction. Bombs at (2,2) (fuse 3) and (4,2) (fuse 1). Required: (2,2) clears, and (4,2) becomes 3 on the same edge, then detonates on the next edge. A player at (6,2) loses 1 health only on the second edge.
- Overlap damage. Two bombs detonating on the same edge, both covering P1. Required: P1 health drops by exactly 1.
- Placement rules. Held i_place with MAX_BOMBS=1 yields exactly one bomb until it explodes. P0 and P1 requesting the same empty cell yields owner 0. Placement into a cell under this edge's blast is rejected.
- Game end. P1 health 1, hit: o_alive = 01, o_game_over = 1, o_winner = 0. Subsequent requests are ignored. rst restores health 3 and clears o_game_over. Simultaneous kill of both players: o_draw = 1.

Source files
------------

// File: rtl/bomb_engine.sv
// Purpose: bomb grid engine; fuses, cross blasts, chain reactions, player damage, game-over tracking.
// Latency: every update lands on the bombClk edge that samples the inputs; all outputs are registered.
// Backpressure: none; rejected placement requests are dropped and must be held or re-issued.
module bomb_engine #(
  parameter int GRID_W      = 10,
  parameter int GRID_H      = 10,
  parameter int CW          = 4,
  parameter int FUSE_LEN    = 3,
  parameter int FW          = 2,
  parameter int BLAST_R     = 2,
  parameter int NUM_PLAYERS = 2,
  parameter int HW          = 2,
  parameter int MAX_HEALTH  = 3,
  parameter int MAX_BOMBS   = 1
) (
  input  logic                          bombClk,
  input  logic                          rst,
  input  logic [NUM_PLAYERS-1:0]        i_place,
  input  logic [NUM_PLAYERS*CW-1:0]     i_posX,
  input  logic [NUM_PLAYERS*CW-1:0]     i_posY,
  output logic [GRID_W*GRID_H*FW-1:0]   o_bombMap,
  output logic [GRID_W*GRID_H-1:0]      o_blastMap,
  output logic [NUM_PLAYERS*HW-1:0]     o_health,
  output logic [NUM_PLAYERS-1:0]        o_alive,
  output logic                          o_game_over,
  output logic [1:0]                    o_winner,
  output logic                          o_draw
);

  localparam int NC   = GRID_W * GRID_H;
  localparam int CNTW = $clog2(MAX_BOMBS + 1);
  localparam logic [FW-1:0]   FL      = FW'(FUSE_LEN);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_BOMBS);

  // Registered state
  logic [FW-1:0]   fuse_q   [NC];
  logic [FW-1:0]   fuse_d   [NC];
  logic [1:0]      owner_q  [NC];
  logic [1:0]      owner_d  [NC];
  logic [NC-1:0]   blast_q, blast_d;
  logic [CNTW-1:0] cnt_q    [NUM_PLAYERS];
  logic [CNTW-1:0] cnt_d    [NUM_PLAYERS];
  logic [HW-1:0]   health_q [NUM_PLAYERS];
  logic [HW-1:0]   health_d [NUM_PLAYERS];
  logic            over_q, over_d;
  logic            draw_q, draw_d;
  logic [1:0]      winner_q, winner_d;

  // Combinational helpers
  logic [NC-1:0]          det;
  logic [NC-1:0]          blast_set;
  logic [NUM_PLAYERS-1:0] alive_pre;
  logic [NUM_PLAYERS-1:0] in_range;
  int                     pcell [NUM_PLAYERS];

  // Detonating cells and the union of their clipped crosses
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      det[c] = (fuse_q[c] == FL);
    end
    blast_set = '0;
    for (int y = 0; y < GRID_H; y++) begin
      for (int x = 0; x < GRID_W; x++) begin
        if (det[y*GRID_W + x]) begin
          // Iterating over real grid cells keeps the cross clipped with no wrap.
          for (int xx = 0; xx < GRID_W; xx++) begin
            if ((xx - x <= BLAST_R) && (x - xx <= BLAST_R)) blast_set[y*GRID_W + xx] = 1'b1;
          end
          for (int yy = 0; yy < GRID_H; yy++) begin
            if ((yy - y <= BLAST_R) && (y - yy <= BLAST_R)) blast_set[yy*GRID_W + x] = 1'b1;
          end
        end
      end
    end
  end

  // Player position decode; off-grid players map to cell 0 but are masked by in_range
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      alive_pre[p] = |health_q[p];
      in_range[p]  = (int'(i_posX[p*CW +: CW]) < GRID_W) && (int'(i_posY[p*CW +: CW]) < GRID_H);
      pcell[p]     = in_range[p] ? (int'(i_posY[p*CW +: CW]) * GRID_W + int'(i_posX[p*CW +: CW])) : 0;
    end
  end

  // Next-state: explosions, chains, fuse advance, damage, placement, game-over
  always_comb begin
    logic [2:0] n_alive;
    logic [1:0] last_alive;
    for (int c = 0; c < NC; c++) begin
      fuse_d[c]  = fuse_q[c];
      owner_d[c] = owner_q[c];
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      cnt_d[p]    = cnt_q[p];
      health_d[p] = health_q[p];
    end
    blast_d    = blast_q;
    over_d     = over_q;
    draw_d     = draw_q;
    winner_d   = winner_q;
    n_alive    = '0;
    last_alive = '0;

    if (over_q) begin
      // Frozen after game over; only the blast display is wiped.
      blast_d = '0;
    end else begin
      blast_d = blast_set;

      for (int c = 0; c < NC; c++) begin
        if (det[c]) begin
          fuse_d[c] = '0;
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (owner_q[c] == 2'(p)) cnt_d[p] = cnt_d[p] - CNTW'(1);
          end
        end else if (fuse_q[c] != '0) begin
          // A ticking bomb caught in the blast jumps to the last fuse state.
          fuse_d[c] = blast_set[c] ? FL : fuse_q[c] + FW'(1);
        end
      end

      // One point of damage per edge, however many crosses overlap.
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (alive_pre[p] && in_range[p] && blast_set[pcell[p]]) begin
          health_d[p] = health_q[p] - HW'(1);
        end
      end

      // Ascending order: a lower-index winner already made fuse_d nonzero for the cell.
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (i_place[p] && alive_pre[p] && in_range[p] &&
            (fuse_q[pcell[p]] == '0) && (fuse_d[pcell[p]] == '0) &&
            !blast_set[pcell[p]] && (cnt_q[p] < CNT_MAX)) begin
          fuse_d[pcell[p]]  = FW'(1);
          owner_d[pcell[p]] = 2'(p);
          cnt_d[p]          = cnt_d[p] + CNTW'(1);
        end
      end

      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (health_d[p] != '0) begin
          n_alive    = n_alive + 3'd1;
          last_alive = 2'(p);
        end
      end
      if (n_alive <= 3'd1) begin
        over_d   = 1'b1;
        draw_d   = (n_alive == 3'd0);
        winner_d = (n_alive == 3'd1) ? last_alive : 2'd0;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge bombClk) begin
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        fuse_q[c]  <= '0;
        owner_q[c] <= '0;
      end
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        cnt_q[p]    <= '0;
        health_q[p] <= HW'(MAX_HEALTH);
      end
      blast_q  <= '0;
      over_q   <= 1'b0;
      draw_q   <= 1'b0;
      winner_q <= 2'd0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        fuse_q[c]  <= fuse_d[c];
        owner_q[c] <= owner_d[c];
      end
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        cnt_q[p]    <= cnt_d[p];
        health_q[p] <= health_d[p];
      end
      blast_q  <= blast_d;
      over_q   <= over_d;
      draw_q   <= draw_d;
      winner_q <= winner_d;
    end
  end

  // Output packing straight from registers
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      o_bombMap[c*FW +: FW] = fuse_q[c];
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      o_health[p*HW +: HW] = health_q[p];
      o_alive[p]           = |health_q[p];
    end
    o_blastMap  = blast_q;
    o_game_over = over_q;
    o_winner    = winner_q;
    o_draw      = draw_q;
  end

endmodule

// File: tb/tb_bomb_engine.sv
// Directed bench for bomb_engine at default parameters (10x10, fuse 3, radius 2, 2 players).
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_bomb_engine;

  logic         bombClk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   i_place = 2'b00;
  logic [7:0]   i_posX = '0;
  logic [7:0]   i_posY = '0;
  logic [199:0] o_bombMap;
  logic [99:0]  o_blastMap;
  logic [3:0]   o_health;
  logic [1:0]   o_alive;
  logic         o_game_over;
  logic [1:0]   o_winner;
  logic         o_draw;

  int n_cmp = 0;
  int n_err = 0;

  bomb_engine dut (
    .bombClk(bombClk), .rst(rst), .i_place(i_place), .i_posX(i_posX), .i_posY(i_posY),
    .o_bombMap(o_bombMap), .o_blastMap(o_blastMap), .o_health(o_health), .o_alive(o_alive),
    .o_game_over(o_game_over), .o_winner(o_winner), .o_draw(o_draw)
  );

  always #5 bombClk = ~bombClk;

  task automatic step();
    @(posedge bombClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setpos(input int p, input int x, input int y);
    i_posX[p*4 +: 4] = 4'(x);
    i_posY[p*4 +: 4] = 4'(y);
  endtask

  function automatic logic [1:0] fuse_at(input int x, input int y);
    return o_bombMap[(y*10 + x)*2 +: 2];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    i_place = 2'b00;
    step();
    rst = 1'b0;
  endtask

  // P0 drops a bomb at (0,0), walks to (p0x,p0y) and the bomb detonates on the 4th edge.
  task automatic round(input int p0x, input int p0y, input int p1x, input int p1y);
    setpos(1, p1x, p1y);
    setpos(0, 0, 0);
    i_place = 2'b01;
    step();
    i_place = 2'b00;
    setpos(0, p0x, p0y);
    step();
    step();
    step();
  endtask

  int cross33[9] = '{13, 23, 31, 32, 33, 34, 35, 43, 53};
  int cross00[5] = '{0, 1, 2, 10, 20};
  logic [99:0] exp_b;

  initial begin
    // ---- Reset state and default fuse sequence ----
    setpos(0, 3, 3);
    setpos(1, 9, 9);
    do_reset();
    chk("rst_health", o_health, 4'hF);
    chk("rst_alive", o_alive, 2'b11);
    chk("rst_over", o_game_over, 1'b0);
    chk("rst_winner", o_winner, 2'd0);
    chk("rst_draw", o_draw, 1'b0);
    chk("rst_bombmap", o_bombMap, 200'd0);
    chk("rst_blastmap", o_blastMap, 100'd0);

    i_place = 2'b01;
    step();
    chk("fuse1", fuse_at(3, 3), 2'd1);
    setpos(0, 7, 3);
    step();
    chk("fuse2", fuse_at(3, 3), 2'd2);
    chk("held_place_limit", fuse_at(7, 3), 2'd0);
    setpos(0, 3, 3);
    step();
    chk("fuse3", fuse_at(3, 3), 2'd3);
    step();
    exp_b = '0;
    for (int i = 0; i < 9; i++) exp_b[cross33[i]] = 1'b1;
    chk("detonate_fuse", fuse_at(3, 3), 2'd0);
    chk("cross_3_3", o_blastMap, exp_b);
    chk("self_hit_health", o_health, 4'hE);
    step();
    chk("replace_after_boom", fuse_at(3, 3), 2'd1);
    chk("blast_cleared", o_blastMap, 100'd0);

    // ---- Edge clipping ----
    do_reset();
    setpos(0, 0, 0);
    setpos(1, 9, 9);
    i_place = 2'b01;
    step();
    i_place = 2'b00;
    setpos(0, 9, 8);
    step();
    step();
    step();
    exp_b = '0;
    for (int i = 0; i < 5; i++) exp_b[cross00[i]] = 1'b1;
    chk("clip_cross_0_0", o_blastMap, exp_b);
    chk("clip_fuse", fuse_at(0, 0), 2'd0);
    chk("clip_health", o_health, 4'hF);

    // ---- Chain reaction ----
    do_reset();
    setpos(0, 2, 2);
    setpos(1, 4, 2);
    i_place = 2'b01;
    step();
    i_place = 2'b00;
    setpos(0, 9, 9);
    step();
    i_place = 2'b10;
    step();
    chk("chain_setup_a", fuse_at(2, 2), 2'd3);
    chk("chain_setup_b", fuse_at(4, 2), 2'd1);
    i_place = 2'b00;
    setpos(1, 6, 2);
    step();
    chk("chain_first_clear", fuse_at(2, 2), 2'd0);
    chk("chain_promoted", fuse_at(4, 2), 2'd3);
    chk("chain_no_hit_yet", o_health, 4'hF);
    step();
    chk("chain_second_clear", fuse_at(4, 2), 2'd0);
    chk("chain_hit", o_health, 4'hB);

    // ---- Overlapping crosses damage once ----
    do_reset();
    setpos(0, 2, 5);
    setpos(1, 4, 5);
    i_place = 2'b11;
    step();
    chk("overlap_place_p0", fuse_at(2, 5), 2'd1);
    chk("overlap_place_p1", fuse_at(4, 5), 2'd1);
    i_place = 2'b00;
    setpos(0, 9, 9);
    setpos(1, 3, 5);
    step();
    step();
    step();
    chk("overlap_health", o_health, 4'hB);

    // ---- Same-cell conflict: lowest index owns the bomb ----
    do_reset();
    setpos(0, 5, 5);
    setpos(1, 5, 5);
    i_place = 2'b11;
    step();
    chk("conflict_placed", fuse_at(5, 5), 2'd1);
    setpos(0, 1, 1);
    setpos(1, 7, 7);
    step();
    chk("conflict_p1_free", fuse_at(7, 7), 2'd1);
    chk("conflict_p0_full", fuse_at(1, 1), 2'd0);

    // ---- Placement into this edge's blast is rejected ----
    do_reset();
    setpos(0, 5, 5);
    setpos(1, 9, 0);
    i_place = 2'b01;
    step();
    i_place = 2'b00;
    setpos(0, 0, 9);
    step();
    step();
    setpos(1, 6, 5);
    i_place = 2'b10;
    step();
    chk("blast_reject", fuse_at(6, 5), 2'd0);
    chk("blast_reject_hit", o_health, 4'hB);
    step();
    chk("after_blast_accept", fuse_at(6, 5), 2'd1);

    // ---- Game end: P0 wins ----
    do_reset();
    round(9, 9, 2, 0);
    chk("ge_round1", o_health, 4'hB);
    round(9, 9, 2, 0);
    chk("ge_round2", o_health, 4'h7);
    chk("ge_not_over", o_game_over, 1'b0);
    round(9, 9, 2, 0);
    chk("ge_alive", o_alive, 2'b01);
    chk("ge_over", o_game_over, 1'b1);
    chk("ge_winner", o_winner, 2'd0);
    chk("ge_draw", o_draw, 1'b0);
    setpos(0, 5, 5);
    i_place = 2'b01;
    step();
    chk("ge_frozen_place", fuse_at(5, 5), 2'd0);
    chk("ge_blast_wiped", o_blastMap, 100'd0);
    chk("ge_frozen_health", o_health, 4'h3);
    chk("ge_still_over", o_game_over, 1'b1);
    do_reset();
    chk("ge_rst_health", o_health, 4'hF);
    chk("ge_rst_over", o_game_over, 1'b0);
    chk("ge_rst_alive", o_alive, 2'b11);

    // ---- Game end: P1 wins ----
    round(1, 0, 9, 9);
    round(1, 0, 9, 9);
    round(1, 0, 9, 9);
    chk("p1win_health", o_health, 4'hC);
    chk("p1win_alive", o_alive, 2'b10);
    chk("p1win_over", o_game_over, 1'b1);
    chk("p1win_winner", o_winner, 2'd1);

    // ---- Simultaneous kill: draw ----
    do_reset();
    round(1, 0, 0, 1);
    round(1, 0, 0, 1);
    round(1, 0, 0, 1);
    chk("draw_alive", o_alive, 2'b00);
    chk("draw_over", o_game_over, 1'b1);
    chk("draw_flag", o_draw, 1'b1);
    chk("draw_winner", o_winner, 2'd0);
    chk("draw_health", o_health, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
